// File: rtl/display_pkg.sv
// Shared definitions for the seven-segment display path: digit width,
// scan sequencer states and the "all anodes dark" pattern.
package display_pkg;

   localparam int DIGIT_W    = 4;
   localparam int MAX_DIGITS = 8;

   // Anodes are active-low, so all ones turns every digit off.
   localparam logic [MAX_DIGITS-1:0] BLANK_AN = '1;

   typedef enum logic {
      OFF,
      SCAN
   } scan_state_t;

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Valid/ready load port carrying one nibble per digit into the scan controller.
interface display_scan_ctrl_if #(
   parameter int NUM_DIGITS = 4
);
   import display_pkg::*;

   logic                          load_valid;
   logic                          load_ready;
   logic [DIGIT_W*NUM_DIGITS-1:0] load_data;

   modport master (
      output load_valid,
      output load_data,
      input  load_ready
   );

   modport slave (
      input  load_valid,
      input  load_data,
      output load_ready
   );

endinterface

// File: rtl/refresh_prescaler.sv
// Free-running divider with enable and synchronous clear; tc is high during
// the last count of each period so the caller can step on it.
module refresh_prescaler #(
   parameter int DIV   = 4,
   parameter int CNT_W = (DIV > 1) ? $clog2(DIV) : 1
) (
   input  logic clk,
   input  logic arst,
   input  logic en,
   input  logic clr,
   output logic tc
);

   logic [CNT_W-1:0] count;

   assign tc = en && (count == CNT_W'(DIV - 1));

   // Count 0..DIV-1 while enabled, wrapping on terminal count; clear wins.
   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= tc ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed seven-segment scan sequencer. Walks a digit index at the
// refresh rate, drives the shared digit code and active-low anodes, and
// swaps in new display content only at a frame boundary (or while dark).
module display_scan_ctrl
   import display_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int IDX_W       = $clog2(NUM_DIGITS)
) (
   input  logic                   clk,
   input  logic                   arst,
   input  logic                   en,
   input  logic                   lz_blank,
   display_scan_ctrl_if.slave     load,
   output logic [DIGIT_W-1:0]     digit_code,
   output logic [IDX_W-1:0]       digit_idx,
   output logic [NUM_DIGITS-1:0]  an,
   output logic                   frame_tick
);

   localparam int               DATA_W   = DIGIT_W * NUM_DIGITS;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

   scan_state_t           state;
   logic [DATA_W-1:0]     active;
   logic [DATA_W-1:0]     pending;
   logic                  pending_full;

   logic                  scan;
   logic                  tc;
   logic                  frame_end;
   logic                  commit;
   logic                  accept;
   logic [DATA_W-1:0]     active_next;
   logic [IDX_W-1:0]      idx_next;
   logic [DIGIT_W-1:0]    code_next;
   logic [NUM_DIGITS-1:0] an_next;
   logic                  zero_above;

   // The prescaler only runs while actually scanning; leaving SCAN or
   // dropping en parks it at zero so the next scan starts a fresh slot.
   assign scan = (state == SCAN) && en;

   refresh_prescaler #(
      .DIV (REFRESH_DIV)
   ) u_prescaler (
      .clk  (clk),
      .arst (arst),
      .en   (scan),
      .clr  (!scan),
      .tc   (tc)
   );

   assign frame_end        = tc && (digit_idx == LAST_IDX);
   assign commit           = pending_full && ((state == OFF) || frame_end);
   assign accept           = load.load_valid && !pending_full;
   assign active_next      = commit ? pending : active;
   assign load.load_ready  = !pending_full;

   // Next digit index: hold within a slot, step on terminal count, wrap at the last digit.
   always_comb begin
      idx_next = '0;
      if (scan) begin
         if (tc) begin
            idx_next = frame_end ? '0 : digit_idx + 1'b1;
         end else begin
            idx_next = digit_idx;
         end
      end
   end

   // Select the nibble for the next lit digit and decide whether its anode is
   // suppressed as a leading zero (it and every higher digit are zero).
   always_comb begin
      code_next  = '0;
      an_next    = BLANK_AN[NUM_DIGITS-1:0];
      zero_above = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_above = zero_above && (active_next[i*DIGIT_W +: DIGIT_W] == '0);
         if (idx_next == IDX_W'(i)) begin
            code_next  = active_next[i*DIGIT_W +: DIGIT_W];
            an_next[i] = lz_blank && zero_above && (i != 0);
         end
      end
   end

   // Scan FSM with the load buffer and registered display outputs.
   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         state        <= OFF;
         active       <= '0;
         pending      <= '0;
         pending_full <= 1'b0;
         digit_idx    <= '0;
         digit_code   <= '0;
         an           <= BLANK_AN[NUM_DIGITS-1:0];
         frame_tick   <= 1'b0;
      end else begin
         frame_tick <= frame_end;

         if (commit) begin
            active       <= pending;
            pending_full <= 1'b0;
         end else if (accept) begin
            pending      <= load.load_data;
            pending_full <= 1'b1;
         end

         case (state)
            OFF:     if (en)  state <= SCAN;
            SCAN:    if (!en) state <= OFF;
            default: state <= OFF;
         endcase

         if (en) begin
            digit_idx  <= idx_next;
            digit_code <= code_next;
            an         <= an_next;
         end else begin
            digit_idx  <= '0;
            digit_code <= '0;
            an         <= BLANK_AN[NUM_DIGITS-1:0];
         end
      end
   end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Sequencer for the multiplexed seven-segment display path. Holds one nibble per digit, walks a refresh index across the digits at a programmable rate, and drives the shared digit code (into the seven_seg_dis decoder) plus active-low anode enables. New display content arrives through a valid/ready load port and is committed only at a frame boundary, so a frame never mixes old and new digits. Replaces the free-running toggle select of the two-digit path and scales to NUM_DIGITS digits.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
REFRESH_DIV, 50000, clk cycles each digit stays lit (>=2)
IDX_W, $clog2(NUM_DIGITS), width of digit index

Ports:
clk  input  1  system clock
arst  input  1  asynchronous reset, active-low
en  input  1  1 = scan display; 0 = all digits dark
lz_blank  input  1  1 = suppress leading-zero digits
load_valid  input  1  load_data is valid
load_ready  output  1  controller can accept a load
load_data  input  4*NUM_DIGITS  digit nibbles, [3:0] = digit 0 (least significant)
digit_code  output  4  nibble for the currently lit digit
digit_idx  output  IDX_W  index of the currently lit digit
an  output  NUM_DIGITS  anode enables, active-low, at most one bit low
frame_tick  output  1  one-cycle pulse when the last digit's slot ends

Behaviour:
- Reset (arst=0, async): active and pending registers = 0, pending_full=0, prescaler=0, idx=0, state OFF. Outputs: an all 1, digit_code 0, digit_idx 0, load_ready 1, frame_tick 0. Any pending load is discarded.
- States: OFF, SCAN.
  OFF: prescaler held at 0, idx=0, an all 1. When en=1, go to SCAN. an/digit_code show digit 0 on the next cycle.
  SCAN: prescaler counts 0..REFRESH_DIV-1. At terminal count, idx advances and wraps from NUM_DIGITS-1 to 0. When en=0, go to OFF. an goes all 1 on the next cycle and idx returns to 0.
- All outputs are registered. an, digit_code and digit_idx change on the cycle after the prescaler terminal count.
- frame_tick: 1 for exactly one cycle when the prescaler hits terminal count with idx==NUM_DIGITS-1. Never asserted in OFF.
- Load handshake:
  - load_ready = !pending_full.
  - When load_valid && load_ready: capture load_data into pending and set pending_full. load_ready drops the next cycle.
  - load_valid while load_ready=0 has no effect. The source must hold its data until accepted.
- Commit: pending is copied to active and pending_full is cleared, so load_ready=1 on the next cycle. Commit happens:
  - in SCAN, on the frame_tick cycle;
  - in OFF, on the first cycle after acceptance.
  Accept and commit can never fall in the same cycle.
- digit_code = active nibble[idx]. Values 10..15 pass through unchanged; decoding is downstream.
- Leading-zero blanking: when lz_blank=1, digit i (i>0) keeps its an bit high if active nibbles i..NUM_DIGITS-1 are all zero. Digit 0 is never blanked. Timing and digit_code are unaffected.
- en deasserted mid-frame: no commit occurs until OFF is reached, then the OFF commit rule applies.

Decomposition:
- Shared package display_pkg: DIGIT_W=4, scan_state_t enum {OFF, SCAN}, BLANK_AN constant (all ones).
- One natural sub-module: refresh_prescaler (counter with enable, synchronous clear, terminal-count pulse), reusable by other display blocks.
- Everything else stays in display_scan_ctrl.

Test Plan:
(All with NUM_DIGITS=4, REFRESH_DIV=4.)
1. Reset, en=1, load 0x1234 in OFF. Expect:
   - load_ready low for 1 cycle;
   - then an cycles 1110,1101,1011,0111 with digit_code 4,3,2,1, each held 4 cycles;
   - frame_tick every 16 cycles.
2. Mid-frame while showing 0x1234, load 0x5678. Expect:
   - remaining digits of the frame still show 3,2,1;
   - load_ready low until the frame_tick cycle;
   - the next frame shows 8,7,6,5.
3. Hold load_valid with 0x9999 while load_ready=0. Expect the second data value to be ignored until ready; exactly one commit per frame.
4. lz_blank=1, load 0x0030. Expect:
   - an bits 3 and 2 stay high during their slots;
   - digit 1 lit with code 3, digit 0 lit with code 0.
   Load 0x0000: only digit 0 lights.
5. Drop en in digit 2's slot. Expect an=1111 and digit_idx=0 on the next cycle, frame_tick silent. Restore en: scan resumes at digit 0.
6. Assert arst mid-scan with a pending load. Expect outputs at reset values immediately (asynchronously). After release, the display shows 0 (pending discarded) and load_ready=1.
